// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer: queues {J,K} commands in a small FIFO and replays each one
// on registered J/K outputs for cmd_len+1 cycles, back to back when the queue
// is non-empty. q_model tracks the Q a downstream JK flip-flop would hold.
module jk_cmd_sequencer #(
  parameter int DEPTH = 4  // legal: 2, 4, 8
) (
  input  logic       CLK,
  input  logic       Clear,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_len,
  output logic       J,
  output logic       K,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       q_model
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [3:0]      CNT_ONE   = 4'd1;
  localparam logic [3:0]      DEPTH_CNT = 4'(DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;

  // Next Q of a JK flip-flop: 00 keep, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nq;
    case ({j, k})
      2'b00:   nq = q;
      2'b01:   nq = 1'b0;
      2'b10:   nq = 1'b1;
      default: nq = ~q;
    endcase
    return nq;
  endfunction

  logic [1:0]       r_op_mem  [DEPTH];
  logic [2:0]       r_len_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;
  logic [0:0]       r_state;
  logic [2:0]       r_rem;
  logic             r_j;
  logic             r_k;
  logic             r_busy;
  logic             r_q;

  logic       w_ready;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head_op;
  logic [2:0] w_head_len;

  // Ready depends only on the registered count, so a pop on the same edge
  // never lets an extra push in.
  assign w_ready    = (r_count < DEPTH_CNT);
  assign w_push     = cmd_valid & w_ready;
  assign w_pop      = (r_count != 4'd0) &&
                      ((r_state == S_IDLE) || (r_rem == 3'd0));
  assign w_head_op  = r_op_mem[r_rd_ptr];
  assign w_head_len = r_len_mem[r_rd_ptr];

  assign cmd_ready  = w_ready;
  assign J          = r_j;
  assign K          = r_k;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign q_model    = r_q;

  // FIFO storage: data only, validity is carried by pointers and count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]  <= cmd_op;
      r_len_mem[r_wr_ptr] <= cmd_len;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!Clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Issue FSM: load J/K from the FIFO head and hold for len+1 cycles,
  // chaining straight into the next command when one is queued.
  always_ff @(posedge CLK) begin
    if (!Clear) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state      <= S_ISSUE;
            {r_j, r_k}   <= w_head_op;
            r_rem        <= w_head_len;
            r_busy       <= 1'b1;
          end else begin
            {r_j, r_k}   <= 2'b00;
            r_busy       <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_rem != 3'd0) begin
            r_rem        <= r_rem - 3'd1;
          end else if (w_pop) begin
            {r_j, r_k}   <= w_head_op;
            r_rem        <= w_head_len;
          end else begin
            r_state      <= S_IDLE;
            {r_j, r_k}   <= 2'b00;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          {r_j, r_k} <= 2'b00;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Model of the downstream flip-flop, fed by the current registered J/K.
  always_ff @(posedge CLK) begin
    if (!Clear) r_q <= 1'b0;
    else        r_q <= jk_next(r_q, r_j, r_k);
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer (DEPTH=4).
module tb_jk_cmd_sequencer;

  logic       CLK = 1'b0;
  logic       Clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_len;
  logic       J;
  logic       K;
  logic       busy;
  logic [3:0] fifo_count;
  logic       q_model;

  int tests_run    = 0;
  int tests_failed = 0;

  jk_cmd_sequencer #(.DEPTH(4)) dut (
    .CLK        (CLK),
    .Clear      (Clear),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .J          (J),
    .K          (K),
    .busy       (busy),
    .fifo_count (fifo_count),
    .q_model    (q_model)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic jk_f(input logic q, input logic [1:0] jk);
    case (jk)
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Clear = 1'b0;
    cmd_valid = 1'b0;
    step();
    step();
    Clear = 1'b1;
  endtask

  task automatic test_reset();
    Clear     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_len   = 3'd0;
    step();
    step();
    tests_run++;
    if ({J, K} !== 2'b00 || busy !== 1'b0 || fifo_count !== 4'd0 ||
        q_model !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: jk=%b busy=%b cnt=%0d q=%b rdy=%b, want jk=00 busy=0 cnt=0 q=0 rdy=1",
               {J, K}, busy, fifo_count, q_model, cmd_ready);
    end
    Clear     = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    tests_run++;
    if (busy !== 1'b0 || fifo_count !== 4'd0 || {J, K} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_no_accept: busy=%b cnt=%0d jk=%b, want busy=0 cnt=0 jk=00",
               busy, fifo_count, {J, K});
    end
  endtask

  task automatic test_set_len2();
    logic [1:0] ejk [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b00};
    logic       eb  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ec  [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       eq  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 3'd2;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      tests_run++;
      if ({J, K} !== ejk[i] || busy !== eb[i] || fifo_count !== ec[i] || q_model !== eq[i]) begin
        tests_failed++;
        $display("FAIL set_len2_e%0d: jk=%b busy=%b cnt=%0d q=%b, want jk=%b busy=%b cnt=%0d q=%b",
                 i, {J, K}, busy, fifo_count, q_model, ejk[i], eb[i], ec[i], eq[i]);
      end
    end
  endtask

  task automatic test_toggle();
    logic [1:0] ejk [6] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic       eb  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eq  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 3'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      tests_run++;
      if ({J, K} !== ejk[i] || busy !== eb[i] || q_model !== eq[i]) begin
        tests_failed++;
        $display("FAIL toggle_e%0d: jk=%b busy=%b q=%b, want jk=%b busy=%b q=%b",
                 i, {J, K}, busy, q_model, ejk[i], eb[i], eq[i]);
      end
    end
  endtask

  task automatic test_full();
    logic       iv  [17] = '{1,1,1,1,1,1,1,1,1,1,1,0,0,0,0,0,0};
    logic [1:0] iop [17] = '{2'b10,2'b01,2'b10,2'b11,2'b01,2'b10,2'b10,2'b10,2'b10,
                             2'b10,2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,2'b00};
    logic [2:0] il  [17] = '{3'd7,3'd0,3'd0,3'd1,3'd1,3'd0,3'd0,3'd0,3'd0,
                             3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0};
    logic [1:0] ejk [17] = '{2'b00,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,2'b10,
                             2'b01,2'b10,2'b11,2'b11,2'b01,2'b01,2'b10,2'b00};
    logic [3:0] ec  [17] = '{4'd1,4'd1,4'd2,4'd3,4'd4,4'd4,4'd4,4'd4,4'd4,
                             4'd3,4'd3,4'd2,4'd2,4'd1,4'd1,4'd0,4'd0};
    logic       er  [17] = '{1,1,1,1,0,0,0,0,0,1,1,1,1,1,1,1,1};
    logic       eb  [17] = '{0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    do_reset();
    for (int e = 0; e < 17; e++) begin
      cmd_valid = iv[e]; cmd_op = iop[e]; cmd_len = il[e];
      step();
      tests_run++;
      if ({J, K} !== ejk[e] || fifo_count !== ec[e] || cmd_ready !== er[e] || busy !== eb[e]) begin
        tests_failed++;
        $display("FAIL full_e%0d: jk=%b cnt=%0d rdy=%b busy=%b, want jk=%b cnt=%0d rdy=%b busy=%b",
                 e, {J, K}, fifo_count, cmd_ready, busy, ejk[e], ec[e], er[e], eb[e]);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] ejk [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
    logic       eb  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ec  [4] = '{4'd1, 4'd1, 4'd0, 4'd0};
    logic       eq  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int e = 0; e < 4; e++) begin
      cmd_valid = (e < 2);
      cmd_op    = (e == 0) ? 2'b01 : 2'b10;
      cmd_len   = 3'd0;
      step();
      tests_run++;
      if ({J, K} !== ejk[e] || busy !== eb[e] || fifo_count !== ec[e] || q_model !== eq[e]) begin
        tests_failed++;
        $display("FAIL b2b_e%0d: jk=%b busy=%b cnt=%0d q=%b, want jk=%b busy=%b cnt=%0d q=%b",
                 e, {J, K}, busy, fifo_count, q_model, ejk[e], eb[e], ec[e], eq[e]);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1:0] iop [3] = '{2'b10, 2'b01, 2'b11};
    logic [2:0] il  [3] = '{3'd7, 3'd0, 3'd0};
    do_reset();
    for (int e = 0; e < 3; e++) begin
      cmd_valid = 1'b1; cmd_op = iop[e]; cmd_len = il[e];
      step();
    end
    tests_run++;
    if ({J, K} !== 2'b10 || busy !== 1'b1 || fifo_count !== 4'd2 || q_model !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_pre: jk=%b busy=%b cnt=%0d q=%b, want jk=10 busy=1 cnt=2 q=1",
               {J, K}, busy, fifo_count, q_model);
    end
    Clear = 1'b0; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 3'd0;
    step();
    tests_run++;
    if ({J, K} !== 2'b00 || busy !== 1'b0 || fifo_count !== 4'd0 ||
        q_model !== 1'b0 || cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_clear: jk=%b busy=%b cnt=%0d q=%b rdy=%b, want jk=00 busy=0 cnt=0 q=0 rdy=1",
               {J, K}, busy, fifo_count, q_model, cmd_ready);
    end
    Clear = 1'b1; cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({J, K} !== 2'b00 || busy !== 1'b0 || fifo_count !== 4'd0) begin
        tests_failed++;
        $display("FAIL midreset_after%0d: jk=%b busy=%b cnt=%0d, want jk=00 busy=0 cnt=0",
                 i, {J, K}, busy, fifo_count);
      end
    end
  endtask

  task automatic test_wrap();
    logic [1:0] ops [12] = '{2'b01,2'b10,2'b11,2'b01,2'b11,2'b10,
                             2'b10,2'b01,2'b11,2'b11,2'b01,2'b10};
    logic [1:0] ejk;
    logic [1:0] prev_jk;
    logic [3:0] ec;
    logic       eb;
    logic       eq;
    do_reset();
    prev_jk = 2'b00;
    eq      = 1'b0;
    for (int e = 0; e < 16; e++) begin
      if (e == 0) begin
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_len = 3'd1;
      end else if (e <= 12) begin
        cmd_valid = 1'b1; cmd_op = ops[e-1]; cmd_len = 3'd0;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
      if (e == 0)       ejk = 2'b00;
      else if (e <= 2)  ejk = 2'b10;
      else if (e <= 14) ejk = ops[e-3];
      else              ejk = 2'b00;
      if (e <= 1)       ec = 4'd1;
      else if (e <= 12) ec = 4'd2;
      else if (e == 13) ec = 4'd1;
      else              ec = 4'd0;
      eb = (e >= 1 && e <= 14);
      eq = jk_f(eq, prev_jk);
      prev_jk = ejk;
      tests_run++;
      if ({J, K} !== ejk || fifo_count !== ec || busy !== eb || q_model !== eq) begin
        tests_failed++;
        $display("FAIL wrap_e%0d: jk=%b cnt=%0d busy=%b q=%b, want jk=%b cnt=%0d busy=%b q=%b",
                 e, {J, K}, fifo_count, busy, q_model, ejk, ec, eb, eq);
      end
    end
  endtask

  initial begin
    Clear     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 3'd0;
    test_reset();
    test_set_len2();
    test_toggle();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
